// File: rtl/click_command_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : board_cmd_pkg
// Brief  : Shared types and constants for the minefield click command path.
//          Holds the command FSM state type, the difficulty level codes and
//          the number of cells per axis for each level.
// Rev    : 1.0  initial release
// ============================================================================
package board_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIV_X    = 3'd1,
    DIV_Y    = 3'd2,
    LOOKUP   = 3'd3,
    ISSUE    = 3'd4,
    WAIT_REL = 3'd5
  } cmd_state_t;

  localparam logic [1:0] LVL_EASY    = 2'd0;
  localparam logic [1:0] LVL_MEDIUM  = 2'd1;
  localparam logic [1:0] LVL_HARD    = 2'd2;
  localparam logic [1:0] LVL_INVALID = 2'd3;

  localparam int unsigned CELLS_EASY   = 8;
  localparam int unsigned CELLS_MEDIUM = 10;
  localparam int unsigned CELLS_HARD   = 16;

endpackage
`default_nettype wire

// File: rtl/click_command_encoder_if.sv
`default_nettype none
// ============================================================================
// Module : game_set_if
// Brief  : Board geometry published by the game-settings block.
//          button_size - cell edge length in pixels
//          board_xpos  - left edge of the board in pixels
//          board_ypos  - top edge of the board in pixels
//          button_num  - cells per axis for the active level
//          Modports: master/out drive the geometry, slave/in consume it.
// Rev    : 1.0  initial release
// ============================================================================
interface game_set_if #(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned IND_W   = 5
);

  logic [COORD_W-1:0] button_size;
  logic [COORD_W-1:0] board_xpos;
  logic [COORD_W-1:0] board_ypos;
  logic [IND_W-1:0]   button_num;

  modport master (output button_size, output board_xpos, output board_ypos, output button_num);
  modport slave  (input  button_size, input  board_xpos, input  board_ypos, input  button_num);
  modport out    (output button_size, output board_xpos, output board_ypos, output button_num);
  modport in     (input  button_size, input  board_xpos, input  board_ypos, input  button_num);

endinterface
`default_nettype wire

// File: rtl/click_command_encoder_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Brief  : Level filter for one mouse button. The stable output follows the
//          raw input only after DEBOUNCE_CYCLES consecutive equal samples
//          that differ from the current stable level.
// Ports  : clk      - system clock
//          rst      - asynchronous active-low reset
//          i_btn    - raw button level
//          o_level  - filtered button level
// Rev    : 1.0  initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  i_btn,
  output logic o_level
);

  localparam int unsigned c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);

  logic               r_sample;
  logic               r_stable;
  logic [c_cnt_w-1:0] r_cnt;

  // r_sample registers the raw pin; the counter tracks how many samples in a
  // row disagreed with the stable level and resets on any agreeing sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sample <= i_btn;
      if (r_sample == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sample;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_stable;

endmodule
`default_nettype wire

// File: rtl/click_command_encoder.sv
`default_nettype none
// ============================================================================
// Module : click_command_encoder
// Brief  : Converts mouse button presses over the minefield into cell indices
//          and flag / defuse / explode commands. Cell indices come from a
//          serial divider (one subtract per cycle per axis).
// Config : CLICK_DEBOUNCE_EN - when defined, each button passes through a
//          btn_debounce instance before edge detection.
// Ports  : clk, rst (async active-low), game_en, level, mouse_xpos/ypos,
//          mouse_left/right, mine_arr_easy/medium/hard (indexed [x][y]),
//          gin (board geometry), symbol_ind_x/y, mark_flag, defuse,
//          explode (sticky), busy.
// Rev    : 1.0  initial release
// ============================================================================
module click_command_encoder
  import board_cmd_pkg::*;
#(
  parameter int unsigned COORD_W         = 12,
  parameter int unsigned IND_W           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire                  game_en,
  input  wire  [1:0]           level,
  input  wire  [COORD_W-1:0]   mouse_xpos,
  input  wire  [COORD_W-1:0]   mouse_ypos,
  input  wire                  mouse_left,
  input  wire                  mouse_right,
  input  wire  [7:0][7:0]      mine_arr_easy,
  input  wire  [9:0][9:0]      mine_arr_medium,
  input  wire  [15:0][15:0]    mine_arr_hard,
  game_set_if.in               gin,
  output logic [IND_W-1:0]     symbol_ind_x,
  output logic [IND_W-1:0]     symbol_ind_y,
  output logic                 mark_flag,
  output logic                 defuse,
  output logic                 explode,
  output logic                 busy
);

  if (DEBOUNCE_CYCLES == 0) begin : g_cfg_check
    $error("DEBOUNCE_CYCLES must be nonzero");
  end

  cmd_state_t r_state;
  cmd_state_t w_state_nxt;

  logic w_btn_l;
  logic w_btn_r;

`ifdef CLICK_DEBOUNCE_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (mouse_left),
    .o_level (w_btn_l)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (mouse_right),
    .o_level (w_btn_r)
  );
`else
  assign w_btn_l = mouse_left;
  assign w_btn_r = mouse_right;
`endif

  logic               r_btn_l_q;
  logic               r_btn_r_q;
  logic               r_is_right;
  logic [1:0]         r_level;
  logic [COORD_W-1:0] r_rem;
  logic [COORD_W-1:0] r_y_off;
  logic [IND_W-1:0]   r_q;
  logic [IND_W-1:0]   r_qx;
  logic [IND_W-1:0]   r_qy;
  logic               r_mine;
  logic [IND_W-1:0]   r_ind_x;
  logic [IND_W-1:0]   r_ind_y;
  logic               r_mark_flag;
  logic               r_defuse;
  logic               r_explode;

  logic w_press_l;
  logic w_press_r;
  logic w_accept;
  logic w_miss_in;
  logic w_div_full;
  logic w_div_step;
  logic w_mine;

  assign w_press_l = w_btn_l & ~r_btn_l_q;
  assign w_press_r = w_btn_r & ~r_btn_r_q;
  assign w_accept  = (w_press_l | w_press_r) & game_en & ~r_explode;

  assign w_miss_in = (mouse_xpos < gin.board_xpos) ||
                     (mouse_ypos < gin.board_ypos) ||
                     (gin.button_size == '0)       ||
                     (level == LVL_INVALID);

  // Quotient already at the cell count means the cursor is past the far
  // edge; testing this before subtracting keeps r_q from ever wrapping.
  assign w_div_full = (r_q == gin.button_num);
  assign w_div_step = (r_rem >= gin.button_size);

  // Out-of-range indices for the captured level read as "no mine" so a
  // mismatched button_num can never address outside the selected map.
  always_comb begin
    w_mine = 1'b0;
    case (r_level)
      LVL_EASY: begin
        if (r_qx < IND_W'(CELLS_EASY) && r_qy < IND_W'(CELLS_EASY))
          w_mine = mine_arr_easy[r_qx[2:0]][r_qy[2:0]];
      end
      LVL_MEDIUM: begin
        if (r_qx < IND_W'(CELLS_MEDIUM) && r_qy < IND_W'(CELLS_MEDIUM))
          w_mine = mine_arr_medium[r_qx[3:0]][r_qy[3:0]];
      end
      LVL_HARD: begin
        if (r_qx < IND_W'(CELLS_HARD) && r_qy < IND_W'(CELLS_HARD))
          w_mine = mine_arr_hard[r_qx[3:0]][r_qy[3:0]];
      end
      default: w_mine = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_miss_in ? WAIT_REL : DIV_X;
      end
      DIV_X: begin
        if (w_div_full)       w_state_nxt = WAIT_REL;
        else if (!w_div_step) w_state_nxt = DIV_Y;
      end
      DIV_Y: begin
        if (w_div_full)       w_state_nxt = WAIT_REL;
        else if (!w_div_step) w_state_nxt = LOOKUP;
      end
      LOOKUP:   w_state_nxt = ISSUE;
      ISSUE:    w_state_nxt = WAIT_REL;
      WAIT_REL: begin
        if (!w_btn_l && !w_btn_r) w_state_nxt = IDLE;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_l_q   <= 1'b0;
      r_btn_r_q   <= 1'b0;
      r_is_right  <= 1'b0;
      r_level     <= 2'd0;
      r_rem       <= '0;
      r_y_off     <= '0;
      r_q         <= '0;
      r_qx        <= '0;
      r_qy        <= '0;
      r_mine      <= 1'b0;
      r_ind_x     <= '0;
      r_ind_y     <= '0;
      r_mark_flag <= 1'b0;
      r_defuse    <= 1'b0;
      r_explode   <= 1'b0;
    end else begin
      r_btn_l_q   <= w_btn_l;
      r_btn_r_q   <= w_btn_r;
      r_mark_flag <= 1'b0;
      r_defuse    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Right wins when both buttons rise together.
            r_is_right <= w_press_r;
            r_level    <= level;
            r_rem      <= mouse_xpos - gin.board_xpos;
            r_y_off    <= mouse_ypos - gin.board_ypos;
            r_q        <= '0;
          end
        end
        DIV_X: begin
          if (!w_div_full) begin
            if (w_div_step) begin
              r_rem <= r_rem - gin.button_size;
              r_q   <= r_q + 1'b1;
            end else begin
              r_qx  <= r_q;
              r_rem <= r_y_off;
              r_q   <= '0;
            end
          end
        end
        DIV_Y: begin
          if (!w_div_full) begin
            if (w_div_step) begin
              r_rem <= r_rem - gin.button_size;
              r_q   <= r_q + 1'b1;
            end else begin
              r_qy <= r_q;
            end
          end
        end
        LOOKUP: r_mine <= w_mine;
        ISSUE: begin
          r_ind_x <= r_qx;
          r_ind_y <= r_qy;
          if (r_is_right)  r_mark_flag <= 1'b1;
          else if (r_mine) r_explode   <= 1'b1;
          else             r_defuse    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign symbol_ind_x = r_ind_x;
  assign symbol_ind_y = r_ind_y;
  assign mark_flag    = r_mark_flag;
  assign defuse       = r_defuse;
  assign explode      = r_explode;
  assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_click_command_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_click_command_encoder
// Brief  : Self-checking bench for click_command_encoder. Directed board
//          scenarios followed by random clicks compared against a model
//          that computes cell indices by integer division.
// Rev    : 1.0  initial release
// ============================================================================
module tb_click_command_encoder;

`ifdef CLICK_DEBOUNCE_EN
  localparam int DEB   = 8;
  localparam int EXTRA = DEB + 1;
`else
  localparam int DEB   = 1;
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          game_en = 1'b0;
  logic [1:0]    level = 2'd0;
  logic [11:0]   mouse_xpos = '0;
  logic [11:0]   mouse_ypos = '0;
  logic          mouse_left = 1'b0;
  logic          mouse_right = 1'b0;
  logic [7:0][7:0]   mine_easy = '0;
  logic [9:0][9:0]   mine_medium = '0;
  logic [15:0][15:0] mine_hard = '0;
  logic [4:0]    symbol_ind_x;
  logic [4:0]    symbol_ind_y;
  logic          mark_flag;
  logic          defuse;
  logic          explode;
  logic          busy;

  always #5 clk = ~clk;

  game_set_if #(.COORD_W(12), .IND_W(5)) gin ();

  click_command_encoder #(
    .COORD_W(12), .IND_W(5), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .game_en         (game_en),
    .level           (level),
    .mouse_xpos      (mouse_xpos),
    .mouse_ypos      (mouse_ypos),
    .mouse_left      (mouse_left),
    .mouse_right     (mouse_right),
    .mine_arr_easy   (mine_easy),
    .mine_arr_medium (mine_medium),
    .mine_arr_hard   (mine_hard),
    .gin             (gin),
    .symbol_ind_x    (symbol_ind_x),
    .symbol_ind_y    (symbol_ind_y),
    .mark_flag       (mark_flag),
    .defuse          (defuse),
    .explode         (explode),
    .busy            (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: board geometry and what the board should show.
  int bx = 100, by = 50, bsize = 40, bnum = 8, lvl = 0;
  bit m_expl = 1'b0;
  int m_ix = 0, m_iy = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg();
    gin.board_xpos  = 12'(bx);
    gin.board_ypos  = 12'(by);
    gin.button_size = 12'(bsize);
    gin.button_num  = 5'(bnum);
    level           = 2'(lvl);
  endtask

  function automatic bit mine_at(input int lv, input int qx, input int qy);
    case (lv)
      0: return (qx < 8  && qy < 8)  ? mine_easy[qx[2:0]][qy[2:0]]   : 1'b0;
      1: return (qx < 10 && qy < 10) ? mine_medium[qx[3:0]][qy[3:0]] : 1'b0;
      2: return (qx < 16 && qy < 16) ? mine_hard[qx[3:0]][qy[3:0]]   : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // kind: 0 none, 1 flag, 2 defuse, 3 explode
  task automatic model(input int x, input int y, input bit l, input bit r,
                       output bit acc, output int kind, output int lat);
    int qx, qy;
    acc  = (l | r) && game_en && !m_expl;
    kind = 0;
    lat  = 0;
    if (!acc) return;
    if (x < bx || y < by || bsize == 0 || lvl == 3) return;
    qx = (x - bx) / bsize;
    qy = (y - by) / bsize;
    if (qx >= bnum || qy >= bnum) return;
    lat  = 4 + qx + qy;
    m_ix = qx;
    m_iy = qy;
    if (r) kind = 1;
    else if (mine_at(lvl, qx, qy)) begin kind = 3; m_expl = 1'b1; end
    else kind = 2;
  endtask

  task automatic press(input string tag, input int x, input int y,
                       input bit l, input bit r, input int hold);
    bit acc, busy_seen, expl_prev;
    int kind, lat;
    int first_p = -1, expl_k = -1, nf = 0, nd = 0;
    int h   = hold + EXTRA;
    int win = h + 2 * EXTRA + 60;
    busy_seen = 1'b0;
    model(x, y, l, r, acc, kind, lat);
    @(negedge clk);
    mouse_xpos  = 12'(x);
    mouse_ypos  = 12'(y);
    mouse_left  = l;
    mouse_right = r;
    expl_prev   = explode;
    for (int k = 0; k < win; k++) begin
      @(negedge clk);
      if (mark_flag) begin nf++; if (first_p < 0) first_p = k; end
      if (defuse)    begin nd++; if (first_p < 0) first_p = k; end
      if (explode && !expl_prev && expl_k < 0) expl_k = k;
      expl_prev = explode;
      if (busy) busy_seen = 1'b1;
      if (k == h - 1) begin mouse_left = 1'b0; mouse_right = 1'b0; end
    end
    check({tag, ".flag_cycles"},   nf, (kind == 1) ? 1 : 0);
    check({tag, ".defuse_cycles"}, nd, (kind == 2) ? 1 : 0);
    check({tag, ".explode"},       explode, m_expl);
    check({tag, ".ind_x"},         symbol_ind_x, m_ix);
    check({tag, ".ind_y"},         symbol_ind_y, m_iy);
    check({tag, ".busy_end"},      busy, 0);
    check({tag, ".busy_seen"},     busy_seen, acc);
    if (kind == 1 || kind == 2) check({tag, ".latency"}, first_p, lat + EXTRA);
    if (kind == 3)              check({tag, ".explode_latency"}, expl_k, lat + EXTRA);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mouse_left = 1'b0;
    mouse_right = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_expl = 1'b0;
    m_ix = 0;
    m_iy = 0;
    repeat (EXTRA + 3) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_cfg();
    game_en = 1'b1;
    mine_easy[7][7] = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.ind_x",   symbol_ind_x, 0);
    check("reset.ind_y",   symbol_ind_y, 0);
    check("reset.flag",    mark_flag, 0);
    check("reset.defuse",  defuse, 0);
    check("reset.explode", explode, 0);
    check("reset.busy",    busy, 0);
    rst = 1'b1;
    repeat (EXTRA + 3) @(negedge clk);

    press("t1_flag",     185, 135, 1'b0, 1'b1, 3);
    press("t2_defuse",   100, 50,  1'b1, 1'b0, 3);
    press("t4_left_out", 99,  60,  1'b1, 1'b0, 3);
    press("t4_q_full",   420, 60,  1'b1, 1'b0, 3);
    lvl = 3; apply_cfg();
    press("lvl_invalid", 185, 135, 1'b0, 1'b1, 3);
    lvl = 0; apply_cfg();
    game_en = 1'b0;
    press("game_off",    185, 135, 1'b1, 1'b0, 3);
    game_en = 1'b1;
    press("t5_both",     185, 135, 1'b1, 1'b1, 100);

    // Reset asserted while the x divider is still running.
    @(negedge clk);
    mouse_xpos = 12'd419; mouse_ypos = 12'd60; mouse_right = 1'b1;
    repeat (EXTRA + 3) @(negedge clk);
    check("t5_rst.busy_before", busy, 1);
    #1 rst = 1'b0;
    #1;
    check("t5_rst.ind_x",   symbol_ind_x, 0);
    check("t5_rst.ind_y",   symbol_ind_y, 0);
    check("t5_rst.flag",    mark_flag, 0);
    check("t5_rst.defuse",  defuse, 0);
    check("t5_rst.explode", explode, 0);
    check("t5_rst.busy",    busy, 0);
    mouse_right = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_expl = 1'b0; m_ix = 0; m_iy = 0;
    repeat (EXTRA + 3) @(negedge clk);

`ifdef CLICK_DEBOUNCE_EN
    begin
      int glitch_evt;
      glitch_evt = 0;
      mouse_xpos = 12'd185; mouse_ypos = 12'd135;
      for (int g = 0; g < 3; g++) begin
        mouse_left = 1'b1;
        repeat (3) begin @(negedge clk); glitch_evt += int'(busy) + int'(defuse); end
        mouse_left = 1'b0;
        repeat (5) begin @(negedge clk); glitch_evt += int'(busy) + int'(defuse); end
      end
      repeat (DEB + 4) begin @(negedge clk); glitch_evt += int'(busy) + int'(defuse); end
      check("t6_glitch.activity", glitch_evt, 0);
      press("t6_stable", 185, 135, 1'b1, 1'b0, 1);
    end
`endif

    press("t3_explode",  419, 369, 1'b1, 1'b0, 3);
    press("t3_blocked",  185, 135, 1'b0, 1'b1, 3);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        if (i < 8 && j < 8)   mine_easy[i][j]   = ($urandom_range(0, 99) < 15);
        if (i < 10 && j < 10) mine_medium[i][j] = ($urandom_range(0, 99) < 15);
        mine_hard[i][j] = ($urandom_range(0, 99) < 15);
      end

    for (int it = 0; it < 40; it++) begin
      int x, y, b;
      if (m_expl) do_reset();
      lvl   = int'($urandom_range(0, 2));
      bsize = int'($urandom_range(20, 40));
      bnum  = (lvl == 0) ? 8 : (lvl == 1) ? 10 : 16;
      apply_cfg();
      game_en = ($urandom_range(0, 9) != 0);
      x = bx - 10 + int'($urandom_range(0, bsize * bnum + 20));
      y = by - 10 + int'($urandom_range(0, bsize * bnum + 20));
      b = int'($urandom_range(0, 2));
      press("rnd", x, y, (b != 1), (b != 0), int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
